// File: rtl/imem_rd_arbiter.sv
// ---------------------------------------------------------------------------
// imem_rd_arbiter
//   Shares the single clocked read port of the instruction memory between two
//   requesters: port 0 (instruction fetch) and port 1 (loader/debug/constant
//   reads). One read issues per cycle. The memory answers one cycle after it
//   samples mem_addr, so a one-entry owner register records which port issued
//   the read in flight. The response is steered back to that port.
//
//   Build option:
//     IMEM_ARB_RR_EN  defined   : round-robin with a burst limit of BURST_MAX
//                                 consecutive grants while the other port waits.
//                     undefined : fixed priority; port 0 always wins.
//
//   Ports:
//     clk, rst                 clock (rising edge), async active-high reset
//     m0_valid/m0_addr         port 0 request and byte address
//     m0_ready                 port 0 grant (combinational)
//     m0_rvalid/m0_rdata       port 0 response, one cycle after the grant
//     m1_*                     same set for port 1
//     mem_addr                 address to memory (granted port's, else 0)
//     mem_dout                 memory read data, one cycle after mem_addr
// ---------------------------------------------------------------------------

// Per-port response steering. Data is gated to zero outside the valid cycle
// so a port never sees the other port's read data.
module imem_rd_resp #(
    parameter int D_WIDTH = 32
) (
    input  logic               inflight,
    input  logic [D_WIDTH-1:0] mem_dout,
    output logic               rvalid,
    output logic [D_WIDTH-1:0] rdata
);
    assign rvalid = inflight;
    assign rdata  = inflight ? mem_dout : '0;
endmodule

module imem_rd_arbiter #(
    parameter int A_WIDTH   = 32,
    parameter int D_WIDTH   = 32,
    parameter int BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_valid,
    input  logic [A_WIDTH-1:0] m0_addr,
    output logic               m0_ready,
    output logic               m0_rvalid,
    output logic [D_WIDTH-1:0] m0_rdata,
    input  logic               m1_valid,
    input  logic [A_WIDTH-1:0] m1_addr,
    output logic               m1_ready,
    output logic               m1_rvalid,
    output logic [D_WIDTH-1:0] m1_rdata,
    output logic [A_WIDTH-1:0] mem_addr,
    input  logic [D_WIDTH-1:0] mem_dout
);

    if (BURST_MAX < 1) begin : g_bad_param
        $error("imem_rd_arbiter: BURST_MAX must be >= 1");
    end

    logic [1:0]              req;      // {m1_valid, m0_valid}
    logic [1:0]              gnt;      // one-hot or zero
    logic [1:0]              owner_q;  // port whose read is in flight (one-hot or zero)
    logic [1:0]              rvalid;
    logic [1:0][D_WIDTH-1:0] rdata;

    assign req = {m1_valid, m0_valid};

`ifdef IMEM_ARB_RR_EN
    localparam int             CW      = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BURST_MAX);

    logic          ptr_q, ptr_d;   // port that wins a conflict
    logic [CW-1:0] cnt_q, cnt_d;   // consecutive grants to the current owner
    logic          gnt_port;       // index of the granted port (valid when |gnt)
    logic          oth_port;

    assign gnt_port = gnt[1];
    assign oth_port = ~gnt[1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state: burst count and priority pointer
    always_comb begin
        cnt_d = '0;
        ptr_d = ptr_q;
        if (gnt != 2'b00) begin
            // owner_q holds last cycle's grant, so equality means "same port again"
            if (owner_q == gnt)
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            else
                cnt_d = CW'(1);
            // Hand priority over when the other port is idle (it gets first
            // shot next time) or when this burst has used up its allowance.
            if (!req[oth_port] || cnt_d == CNT_MAX)
                ptr_d = oth_port;
            else
                ptr_d = gnt_port;
        end
    end

    // Output: grant
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt        = 2'b00;
            gnt[ptr_q] = 1'b1;
        end
    end
`else
    // Output: fixed-priority grant, port 0 first
    always_comb begin
        gnt = 2'b00;
        if (req[0])
            gnt = 2'b01;
        else if (req[1])
            gnt = 2'b10;
    end
`endif

    // In-flight owner: reset drops any read in flight, so no late rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            owner_q <= 2'b00;
        else
            owner_q <= gnt;
    end

    assign m0_ready = gnt[0];
    assign m1_ready = gnt[1];

    // Address passes straight through; alignment/wrap is left to the memory.
    always_comb begin
        mem_addr = '0;
        if (gnt[0])
            mem_addr = m0_addr;
        else if (gnt[1])
            mem_addr = m1_addr;
    end

    for (genvar p = 0; p < 2; p++) begin : g_resp
        imem_rd_resp #(.D_WIDTH(D_WIDTH)) u_resp (
            .inflight (owner_q[p]),
            .mem_dout (mem_dout),
            .rvalid   (rvalid[p]),
            .rdata    (rdata[p])
        );
    end

    assign m0_rvalid = rvalid[0];
    assign m0_rdata  = rdata[0];
    assign m1_rvalid = rvalid[1];
    assign m1_rdata  = rdata[1];

    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
        !(gnt[0] && gnt[1]));
    a_gnt_needs_req : assert property (@(posedge clk) disable iff (rst)
        (gnt & ~req) == 2'b00);

endmodule
